// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of an async PWM input; updates land 2 clks after the first sampling edge.
// valid is a one-cycle pulse with no backpressure; stuck flags a timeout (no edge within 2^WIDTH-1 cycles).
module pwm_capture #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             stuck
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             s1, s, s_d;
  logic [WIDTH-1:0] cnt, high_cnt;
  logic             rise, fall, at_max;
  logic             measured, timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s   <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s1  <= pwm_in;
      s   <= s1;
      s_d <= s;
    end
  end

  assign rise   = s & ~s_d;
  assign fall   = ~s & s_d;
  assign at_max = (cnt == CNT_MAX);

  // Any edge beats the timeout, so a period of exactly CNT_MAX is still measured.
  always_comb begin
    state_d  = state_q;
    measured = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          measured = 1'b1;
        end else if (!fall && at_max) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt      <= '0;
      high_cnt <= '0;
      duty     <= '0;
      period   <= '0;
      valid    <= 1'b0;
      stuck    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid   <= measured | timeout;
      if (state_q == IDLE) begin
        if (rise) cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
      end else if (measured) begin
        period <= cnt;
        duty   <= high_cnt;
        stuck  <= 1'b0;
        cnt    <= {{(WIDTH-1){1'b0}}, 1'b1};
      end else if (timeout) begin
        period <= CNT_MAX;
        duty   <= s ? CNT_MAX : '0;
        stuck  <= 1'b1;
      end else begin
        if (fall) high_cnt <= cnt;
        // A fall landing on CNT_MAX parks the counter; the timeout fires next cycle.
        if (!at_max) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture (WIDTH=8): table of PWM pulses with expected results
// queued at drive time and popped whenever the DUT pulses valid.
module tb_pwm_capture;

  logic       clk;
  logic       rst;
  logic       pwm_in;
  logic [7:0] duty;
  logic [7:0] period;
  logic       valid;
  logic       stuck;

  pwm_capture #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .duty   (duty),
    .period (period),
    .valid  (valid),
    .stuck  (stuck)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] d;
    logic [7:0] p;
    logic       st;
    bit         skip;
  } exp_t;

  typedef struct {
    int         h;
    int         l;
    logic [7:0] d;
    logic [7:0] p;
    logic       st;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[13];

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int valid_seen = 0;
  int valid_cyc  = 0;
  int rise_cyc   = 0;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Sample at the falling edge, then return 1 time unit after the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst && valid) begin
      valid_seen++;
      valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        if (e.skip) begin
          check("post_reset_stuck", int'(stuck), 0);
          check("post_reset_duty_le_period", int'(duty <= period), 1);
        end else begin
          check("duty", int'(duty), int'(e.d));
          check("period", int'(period), int'(e.p));
          check("stuck", int'(stuck), int'(e.st));
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic pulse(int h, int l, logic [7:0] d, logic [7:0] p, logic st);
    exp_t e;
    e.d = d; e.p = p; e.st = st; e.skip = 1'b0;
    exp_q.push_back(e);
    pwm_in   = 1'b1;
    rise_cyc = cyc;
    repeat (h) tick();
    pwm_in = 1'b0;
    repeat (l) tick();
  endtask

  task automatic check_zero(string tag);
    check({tag, "_duty"}, int'(duty), 0);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_stuck"}, int'(stuck), 0);
  endtask

  initial begin
    exp_t sk;

    // Each pulse yields one update: measured at the next rise, or a timeout.
    vecs[0]  = '{25,  75,  8'd25,  8'd100, 1'b0};
    vecs[1]  = '{25,  75,  8'd25,  8'd100, 1'b0};
    vecs[2]  = '{25,  75,  8'd25,  8'd100, 1'b0};
    vecs[3]  = '{1,   9,   8'd1,   8'd10,  1'b0};
    vecs[4]  = '{1,   9,   8'd1,   8'd10,  1'b0};
    vecs[5]  = '{1,   9,   8'd1,   8'd10,  1'b0};
    vecs[6]  = '{10,  245, 8'd10,  8'd255, 1'b0};
    vecs[7]  = '{10,  246, 8'd0,   8'd255, 1'b1};
    vecs[8]  = '{30,  70,  8'd30,  8'd100, 1'b0};
    vecs[9]  = '{300, 5,   8'd255, 8'd255, 1'b1};
    vecs[10] = '{40,  60,  8'd40,  8'd100, 1'b0};
    vecs[11] = '{40,  60,  8'd40,  8'd100, 1'b0};
    vecs[12] = '{15,  300, 8'd0,   8'd255, 1'b1};

    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_zero("reset");

    repeat (1000) tick();
    check("idle_valid_count", valid_seen, 0);
    check_zero("idle");

    foreach (vecs[i])
      pulse(vecs[i].h, vecs[i].l, vecs[i].d, vecs[i].p, vecs[i].st);
    repeat (20) tick();
    check("table_queue_drained", exp_q.size(), 0);

    // Reset in the middle of a high phase; pwm_in stays high across it.
    pwm_in = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("mid_reset");
    repeat (10) tick();
    pwm_in = 1'b0;
    repeat (20) tick();
    sk.d = '0; sk.p = '0; sk.st = 1'b0; sk.skip = 1'b1;
    exp_q.push_back(sk);
    pulse(20, 30, 8'd20, 8'd50, 1'b0);
    check("rise_to_valid_latency", valid_cyc - rise_cyc, 3);
    pulse(7, 300, 8'd0, 8'd255, 1'b1);
    repeat (20) tick();
    check("final_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, setting the counter and measurement width in clk cycles.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port pwm_in  input  1  asynchronous PWM waveform to measure.
REQ-005 SHALL have port duty  output  WIDTH  high time of the last complete period, in clk cycles.
REQ-006 SHALL have port period  output  WIDTH  length of the last complete period (rising to rising), in clk cycles.
REQ-007 SHALL have port valid  output  1  single-cycle pulse when duty/period are updated.
REQ-008 SHALL have port stuck  output  1  level; last update was a timeout, not a measured period.

Function
REQ-009 SHALL pass pwm_in through a 2-flop synchronizer (output s), then a third flop (s_d).
REQ-010 SHALL detect a rising edge as s=1 & s_d=0 and a falling edge as s=0 & s_d=1, both combinational from registers.
REQ-011 SHALL implement a two-state FSM: IDLE and MEASURE.
REQ-012 In IDLE, SHALL hold the counter and not time out; on a rising edge, SHALL go to MEASURE with cnt=1 and no valid.
REQ-013 In MEASURE, cnt SHALL increment by 1 per cycle when no edge and no timeout.
REQ-014 On a falling edge in MEASURE, SHALL latch high_cnt <= cnt, which is the number of cycles s was high.
REQ-015 On a rising edge in MEASURE: period<=cnt, duty<=high_cnt, valid=1 next cycle, stuck<=0, cnt<=1, stay in MEASURE.
REQ-016 Timeout SHALL occur in MEASURE when cnt = 2^WIDTH-1 with no edge detected that cycle.
REQ-017 On timeout: period<=all-ones, duty<=all-ones if s=1 else 0, stuck<=1, valid=1 next cycle, go to IDLE.
REQ-018 When an edge and cnt=2^WIDTH-1 coincide, the edge SHALL take priority, so a 255-cycle period at WIDTH=8 is measured, not a timeout.
REQ-019 Latency SHALL be fixed: a pwm_in rise first sampled at clk edge k updates outputs at edge k+2; valid is high for the cycle after edge k+2.
REQ-020 valid SHALL be high for exactly one cycle per update, and never on two consecutive cycles except for back-to-back measurements.
REQ-021 duty and period SHALL hold their values between updates.
REQ-022 Counter arithmetic SHALL be unsigned WIDTH-bit and SHALL never wrap; saturation is handled only by REQ-016.
REQ-023 A one-cycle high pulse of s SHALL measure duty=1.
REQ-024 duty <= period SHALL hold for every measured (non-stuck) update.

Reset
REQ-025 While rst=1 at a clk edge: FSM<=IDLE, cnt<=0, high_cnt<=0, duty<=0, period<=0, valid<=0, stuck<=0, all synchronizer flops<=0.
REQ-026 Reset SHALL take precedence over all edge and timeout events.
REQ-027 Reset mid-measurement SHALL discard the partial period; the first rising edge after reset SHALL produce no valid.
REQ-028 Reset deassertion with pwm_in already high SHALL count as a rising edge once the synchronizer fills (s=1, s_d=0).

Verification (WIDTH=8)
REQ-029 pwm_in high 25 / low 75 cycles, repeated -> first rising edge gives no valid; each later rising edge gives valid with duty=25, period=100, stuck=0.
REQ-030 After one valid measurement, hold pwm_in high -> valid 255 cycles after the last rising detection, with duty=255, period=255, stuck=1, FSM in IDLE; pulses then resume -> stuck=0 on the second valid.
REQ-031 Period exactly 255 (high 10) -> duty=10, period=255, stuck=0; period 256 -> timeout with stuck=1, duty=0.
REQ-032 pwm_in high 1 / low 9 cycles, repeated -> duty=1, period=10 on every valid.
REQ-033 Assert rst for 1 cycle midway through a high phase -> all outputs 0; no valid until two rising edges after reset; the second gives correct values.
REQ-034 Constant pwm_in=0 after reset for 1000 cycles -> valid never asserts, all outputs remain 0.
